// File: rtl/serial_subtractor10_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;
  localparam int WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_subtractor10_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow generated by this bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/serial_subtractor10.sv
// Bit-serial A - B - Bin: a single full-subtractor cell iterated LSB-first,
// with a start/busy/done handshake and held result registers.
//
// state | meaning
// IDLE  | ready for a new operation; results held
// RUN   | one operand bit per cycle through the cell, LSB first
// DONE  | results just updated; done pulse high this cycle
module serial_subtractor10
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic             d_bit;
  logic             borrow_nxt;

  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (borrow_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      work   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            cnt    <= '0;
            ready  <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= borrow_nxt;
          work   <= {d_bit, work[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          // Results are committed on the final bit's edge so they are
          // already valid in the cycle where done is high.
          if (cnt == LAST) begin
            diff  <= {d_bit, work[WIDTH-1:1]};
            bout  <= borrow_nxt;
            ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
